mnist_pixel_streamer: RTL and testbench

Transmit-side source for the first convolution layer. It accepts one binarised 28x28 MNIST image from a byte-wide host write port and stores it. On a start pulse it replays the image as a 1-bit-per-clock raster stream into `conv_layer_1`'s `pixel_in`, with a qualifying valid and frame markers. It sits between the host/UART loader and the CNN pipeline.

---
 rtl/mnist_pkg.sv | 19 +
 rtl/pixel_store.sv | 36 +++
 rtl/mnist_pixel_streamer.sv | 169 ++++++++++++++++
 tb/tb_mnist_pixel_streamer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Purpose: shared constants and types for the MNIST front end and first conv layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mnist_pkg;

  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int IMG_NPIX = IMG_W * IMG_H;

  // Output channel count of conv_layer_1, kept here so both ends agree.
  localparam int CONV1_CH = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } stream_state_t;

endpackage : mnist_pkg

// File: rtl/pixel_store.sv
// Purpose: DEPTH x W image word store, synchronous write, combinational read.
// Latency: write visible on read port the cycle after the write edge; read is 0-cycle.
// Backpressure: none; caller gates we_i.
//
// Ports:
//   clk_i   - core clock
//   we_i    - write enable, stores wdata_i at waddr_i on the rising edge
//   waddr_i - write word address
//   wdata_i - write word
//   raddr_i - read word address
//   rdata_o - word at raddr_i (combinational)
module pixel_store #(
  parameter int DEPTH = 98,
  parameter int W     = 8,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  // No reset: contents are don't-care until a full image has been loaded.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : pixel_store

// File: rtl/mnist_pixel_streamer.sv
// Purpose: load one binarised image from a byte-wide host port, replay it as a 1-bit raster stream.
// Latency: start -> pixel 0 in 1 cycle; frame is WIDTH*HEIGHT consecutive valid cycles.
// Backpressure: none; host uses wr_ready, consumer must sample every cycle; dropped requests pulse wr_err.
//
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   wr_en/wr_data/wr_ready  - host write port, MSB of wr_data is the earliest pixel
//   img_full                - image stored, waiting for start
//   start                   - one-cycle request to stream the stored image
//   pixel_out/pixel_valid   - raster pixel and qualifier to conv_layer_1
//   frame_first/frame_last  - markers on pixel 0 and the final pixel
//   wr_err                  - one-cycle pulse for any dropped write or start
module mnist_pixel_streamer
  import mnist_pkg::*;
#(
  parameter int WIDTH  = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int WR_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [WR_W-1:0] wr_data,
  output logic            wr_ready,
  output logic            img_full,
  input  logic            start,
  output logic            pixel_out,
  output logic            pixel_valid,
  output logic            frame_first,
  output logic            frame_last,
  output logic            wr_err
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int NWORD = NPIX / WR_W;
  localparam int AW    = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int BW    = (WR_W > 1) ? $clog2(WR_W) : 1;

  stream_state_t   state_q;
  logic [AW-1:0]   wr_cnt_q;
  logic [PW-1:0]   pix_cnt_q;   // index of the pixel currently on pixel_out
  logic            wr_ready_q;
  logic            img_full_q;
  logic            pixel_out_q;
  logic            pixel_valid_q;
  logic            frame_first_q;
  logic            frame_last_q;
  logic            wr_err_q;

  logic [PW-1:0]   pix_idx_d;   // pixel to be presented after the next edge
  logic [AW-1:0]   rd_addr;
  logic [BW-1:0]   bit_idx;
  logic [WR_W-1:0] rd_word;
  logic            rd_bit;
  logic            store_we;

  assign store_we = (state_q == LOAD) && wr_en;

  pixel_store #(
    .DEPTH (NWORD),
    .W     (WR_W),
    .AW    (AW)
  ) u_store (
    .clk_i   (clk),
    .we_i    (store_we),
    .waddr_i (wr_cnt_q),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  // Look one pixel ahead so the registered output lands on the right cycle.
  // Index 0 is used both for the start edge and after the last pixel, which
  // keeps the read address inside the store.
  always_comb begin
    pix_idx_d = '0;
    if (state_q == STREAM && pix_cnt_q != PW'(NPIX - 1)) begin
      pix_idx_d = pix_cnt_q + PW'(1);
    end
  end

  assign rd_addr = AW'(pix_idx_d / PW'(WR_W));
  assign bit_idx = BW'(WR_W - 1) - BW'(pix_idx_d % PW'(WR_W));
  assign rd_bit  = rd_word[bit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      wr_cnt_q      <= '0;
      pix_cnt_q     <= '0;
      wr_ready_q    <= 1'b1;
      img_full_q    <= 1'b0;
      pixel_out_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      frame_first_q <= 1'b0;
      frame_last_q  <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      // Stream outputs default to background zeros; STREAM overrides below.
      pixel_out_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      frame_first_q <= 1'b0;
      frame_last_q  <= 1'b0;
      wr_err_q      <= 1'b0;

      case (state_q)
        LOAD: begin
          wr_err_q <= start;
          if (wr_en) begin
            if (wr_cnt_q == AW'(NWORD - 1)) begin
              wr_cnt_q   <= '0;
              state_q    <= READY;
              wr_ready_q <= 1'b0;
              img_full_q <= 1'b1;
            end else begin
              wr_cnt_q <= wr_cnt_q + AW'(1);
            end
          end
        end

        READY: begin
          wr_err_q <= wr_en;
          if (start) begin
            state_q       <= STREAM;
            img_full_q    <= 1'b0;
            pix_cnt_q     <= '0;
            pixel_out_q   <= rd_bit;
            pixel_valid_q <= 1'b1;
            frame_first_q <= 1'b1;
            frame_last_q  <= (NPIX == 1);
          end
        end

        STREAM: begin
          // Simultaneous wr_en and start collapse into one pulse.
          wr_err_q <= wr_en | start;
          if (pix_cnt_q == PW'(NPIX - 1)) begin
            state_q    <= LOAD;
            pix_cnt_q  <= '0;
            wr_ready_q <= 1'b1;
          end else begin
            pix_cnt_q     <= pix_idx_d;
            pixel_out_q   <= rd_bit;
            pixel_valid_q <= 1'b1;
            frame_last_q  <= (pix_idx_d == PW'(NPIX - 1));
          end
        end

        default: begin
          state_q    <= LOAD;
          wr_cnt_q   <= '0;
          pix_cnt_q  <= '0;
          wr_ready_q <= 1'b1;
          img_full_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready    = wr_ready_q;
  assign img_full    = img_full_q;
  assign pixel_out   = pixel_out_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_first = frame_first_q;
  assign frame_last  = frame_last_q;
  assign wr_err      = wr_err_q;

endmodule : mnist_pixel_streamer

// File: tb/tb_mnist_pixel_streamer.sv
// Purpose: self-checking bench for mnist_pixel_streamer against a bit-queue image model.
// Latency: checks 1-cycle start latency, 784-cycle frame, wr_ready return on cycle 785.
// Backpressure: checks dropped writes/starts in every state produce a single wr_err pulse.
module tb_mnist_pixel_streamer;

  localparam int NPIX  = 784;
  localparam int NWORD = 98;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       img_full;
  logic       start;
  logic       pixel_out;
  logic       pixel_valid;
  logic       frame_first;
  logic       frame_last;
  logic       wr_err;

  int checks;
  int errors;

  logic [7:0] img_words [NWORD];
  bit         exp_q [$];

  mnist_pixel_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .img_full    (img_full),
    .start       (start),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .frame_first (frame_first),
    .frame_last  (frame_last),
    .wr_err      (wr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the image is simply the words' bits, earliest pixel first.
  task automatic build_expect();
    exp_q.delete();
    foreach (img_words[w]) begin
      for (int b = 7; b >= 0; b--) exp_q.push_back(img_words[w][b]);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    foreach (img_words[w]) img_words[w] = v;
  endtask

  task automatic fill_rand();
    foreach (img_words[w]) img_words[w] = 8'($urandom);
  endtask

  task automatic load_words(input string tag, input int lo, input int hi, input int max_gap);
    int rdy_mis;
    rdy_mis = 0;
    for (int w = lo; w <= hi; w++) begin
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      if (wr_ready !== 1'b1 || img_full !== 1'b0) rdy_mis++;
      wr_en   = 1'b1;
      wr_data = img_words[w];
      @(negedge clk);
      wr_en   = 1'b0;
      wr_data = 8'($urandom);
    end
    chk({tag, " load_rdy_mis"}, rdy_mis, 0);
  endtask

  task automatic load_full(input string tag, input int max_gap);
    load_words(tag, 0, NWORD - 1, max_gap);
    chk({tag, " img_full"}, img_full, 1);
    chk({tag, " wr_ready_lo"}, wr_ready, 0);
  endtask

  // Called at a negedge in READY. Pulses start, then samples every cycle.
  // Optional injection of wr_en/start in cycle inj_k; optional reset in cycle abort_k.
  task automatic run_frame(input string tag, input int inj_k, input bit inj_we,
                           input bit inj_st, input int abort_k);
    int pix_mis, flag_mis, err_mis, ones, exp_ones, last_val;
    bit exp_err;
    pix_mis = 0; flag_mis = 0; err_mis = 0; ones = 0; exp_ones = 0; last_val = -1;
    build_expect();
    foreach (exp_q[i]) exp_ones += int'(exp_q[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= NPIX; k++) begin
      if (k == abort_k) begin
        chk({tag, " pix_mis_pre_abort"}, pix_mis, 0);
        chk({tag, " valid_pre_abort"}, pixel_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk({tag, " valid_async_rst"}, pixel_valid, 0);
        chk({tag, " pixel_async_rst"}, pixel_out, 0);
        chk({tag, " wr_ready_async_rst"}, wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (pixel_valid !== 1'b1) flag_mis++;
      if (pixel_out !== exp_q[k-1]) pix_mis++;
      if (frame_first !== (k == 1)) flag_mis++;
      if (frame_last !== (k == NPIX)) flag_mis++;
      if (wr_ready !== 1'b0 || img_full !== 1'b0) flag_mis++;
      exp_err = (inj_k != 0) && (k == inj_k + 1);
      if (wr_err !== exp_err) err_mis++;
      if (pixel_out === 1'b1) ones++;
      if (frame_last === 1'b1) last_val = int'(pixel_out);
      if (inj_k != 0 && k == inj_k) begin
        wr_en   = inj_we;
        start   = inj_st;
        wr_data = 8'hFF;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " pix_mis"}, pix_mis, 0);
    chk({tag, " flag_mis"}, flag_mis, 0);
    chk({tag, " err_mis"}, err_mis, 0);
    chk({tag, " ones"}, ones, exp_ones);
    chk({tag, " last_pix"}, last_val, int'(exp_q[NPIX-1]));
    chk({tag, " c785_valid"}, pixel_valid, 0);
    chk({tag, " c785_wr_ready"}, wr_ready, 1);
    chk({tag, " c785_last"}, frame_last, 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst wr_ready", wr_ready, 1);
    chk("rst img_full", img_full, 0);
    chk("rst valid", pixel_valid, 0);
    chk("rst pixel", pixel_out, 0);
    chk("rst first", frame_first, 0);
    chk("rst last", frame_last, 0);
    chk("rst wr_err", wr_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5 image, back-to-back writes.
    fill_const(8'hA5);
    load_full("a5", 0);
    run_frame("a5", 0, 1'b0, 1'b0, 0);

    // One-hot: only the final pixel set.
    fill_const(8'h00);
    img_words[NWORD-1] = 8'h01;
    load_full("onehot", 2);
    run_frame("onehot", 0, 1'b0, 1'b0, 0);

    // start during LOAD after 50 words is dropped.
    fill_rand();
    load_words("partial", 0, 49, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_start wr_err", wr_err, 1);
    chk("load_start valid", pixel_valid, 0);
    chk("load_start wr_ready", wr_ready, 1);
    @(negedge clk);
    chk("load_start wr_err_clr", wr_err, 0);
    load_words("partial", 50, NWORD - 1, 2);
    chk("partial img_full", img_full, 1);

    // wr_en in READY is dropped; image untouched.
    wr_en   = 1'b1;
    wr_data = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ready_wr wr_err", wr_err, 1);
    chk("ready_wr img_full", img_full, 1);
    @(negedge clk);
    chk("ready_wr wr_err_clr", wr_err, 0);

    // Stream with a dropped 0xFF write mid-frame.
    run_frame("inj_we", 100, 1'b1, 1'b0, 0);

    // Next load must start at word 0; a shifted load shows up as pixel errors.
    fill_rand();
    load_full("reload", 3);
    run_frame("inj_both", 300, 1'b1, 1'b1, 0);

    // Reset at pixel 400 (cycle 401), then a fresh load and frame.
    fill_rand();
    load_full("abort", 1);
    run_frame("abort", 0, 1'b0, 1'b0, 401);
    chk("post_abort img_full", img_full, 0);
    chk("post_abort wr_ready", wr_ready, 1);
    fill_rand();
    load_full("after_abort", 2);
    run_frame("after_abort", 0, 1'b0, 1'b0, 0);

    // Back-to-back all-ones then all-zeros.
    fill_const(8'hFF);
    load_full("ones", 0);
    run_frame("ones", 0, 1'b0, 1'b0, 0);
    fill_const(8'h00);
    load_full("zeros", 0);
    run_frame("zeros", 0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mnist_pixel_streamer
